// File: rtl/eth_tx_pkg.sv
// Shared types and defaults for the Ethernet transmit scheduler.
package eth_tx_pkg;
  localparam int LEN_W_DEF   = 11;
  localparam int SLOT_WORDS  = 1024;
  localparam int MIN_LEN_DEF = 60;

  typedef logic [LEN_W_DEF-1:0] len_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STREAM,
    ST_PAD,
    ST_DONE
  } state_t;
endpackage

// File: rtl/eth_tx_sched_if.sv
// Byte stream toward the MAC transmitter, valid/ready handshake.
interface eth_tx_sched_if;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tready;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/eth_tx_prefetch.sv
// Two-word read-ahead buffer and byte unpacker over the 16-bit buffer port.
// First read issues during start; data lands one cycle later; reads stop at 2 words held or in flight.
module eth_tx_prefetch
  import eth_tx_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             active,
  input  logic             slot,
  input  logic [LEN_W-1:0] len,
  input  logic             byte_pop,
  input  logic             last_byte,
  output logic             byte_vld,
  output logic [7:0]       byte_dat,
  output logic             mem_en,
  output logic [LEN_W-1:0] mem_addr,
  input  logic [15:0]      mem_rdata
);
  logic [15:0]      wbuf [2];
  logic             wp, rp, phase, infl;
  logic [1:0]       cnt;
  logic [LEN_W-1:0] widx;
  logic [LEN_W:0]   words;
  logic [LEN_W-2:0] widx_lo;
  logic             issue, push, pop_word;

  assign words    = ({1'b0, len} + (LEN_W+1)'(1)) >> 1;
  assign issue    = active && ((cnt + {1'b0, infl}) < 2'd2) && ({1'b0, widx} < words);
  assign mem_en   = start | issue;
  assign widx_lo  = start ? '0 : widx[LEN_W-2:0];
  assign mem_addr = mem_en ? {slot, widx_lo} : '0;
  assign push     = infl;
  // A word retires on its high byte, or early when the frame ends on its low byte.
  assign pop_word = byte_pop & (phase | last_byte);
  assign byte_vld = (cnt != 2'd0);
  assign byte_dat = phase ? wbuf[rp][15:8] : wbuf[rp][7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf[0] <= '0;
      wbuf[1] <= '0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      phase   <= 1'b0;
      infl    <= 1'b0;
      cnt     <= 2'd0;
      widx    <= '0;
    end else begin
      infl <= mem_en;
      if (start) begin
        cnt   <= 2'd0;
        wp    <= 1'b0;
        rp    <= 1'b0;
        phase <= 1'b0;
        widx  <= LEN_W'(1);
      end else begin
        if (issue) widx <= widx + LEN_W'(1);
        if (push) begin
          wbuf[wp] <= mem_rdata;
          wp       <= ~wp;
        end
        if (pop_word) rp <= ~rp;
        if (byte_pop) phase <= ~pop_word;
        cnt <= cnt + {1'b0, push} - {1'b0, pop_word};
      end
    end
  end
endmodule

// File: rtl/eth_tx_sched.sv
// Two-deep frame queue plus streaming FSM; m_tvalid 3 cycles after an idle accept, 1 byte/cycle.
// Stream holds under m_tready=0. Define ETH_TX_PAD_EN to zero-pad short frames to MIN_LEN.
module eth_tx_sched
  import eth_tx_pkg::*;
#(
  parameter int MIN_LEN = MIN_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_req,
  input  logic [LEN_W-1:0]   tx_len,
  output logic               tx_ready,
  output logic               tx_wr_slot,
  output logic               tx_drop,
  output logic               tx_busy,
  output logic               tx_done,
  output logic               mem_en,
  output logic [LEN_W-1:0]   mem_addr,
  input  logic [15:0]        mem_rdata,
  eth_tx_sched_if.master     m_axis
);
  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q [2];
  logic [LEN_W-1:0] cur_len, rem_q;
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic             accept, done, hs, last_cnt, pad_act;
  logic             stream_vld, byte_vld;
  logic [7:0]       byte_dat;

  assign cur_len  = len_q[rd_ptr];
  assign tx_ready = (count != 2'd2);
  assign tx_wr_slot = wr_ptr;
  assign accept   = tx_req && tx_ready && (tx_len != '0);
  assign done     = (state_q == ST_DONE);
  assign tx_done  = done;
  assign tx_busy  = (state_q != ST_IDLE);
  assign last_cnt = (rem_q == LEN_W'(1));

`ifdef ETH_TX_PAD_EN
  assign pad_act = (cur_len < LEN_W'(MIN_LEN));
`else
  assign pad_act = 1'b0;
`endif

  assign stream_vld      = (state_q == ST_STREAM) && byte_vld;
  assign hs              = m_axis.m_tvalid && m_axis.m_tready;
  assign m_axis.m_tvalid = stream_vld || (state_q == ST_PAD);
  assign m_axis.m_tdata  = stream_vld ? byte_dat : 8'h00;
  assign m_axis.m_tlast  = (stream_vld && last_cnt && !pad_act) ||
                           ((state_q == ST_PAD) && last_cnt);

  eth_tx_prefetch #(.LEN_W(LEN_W)) u_prefetch (
    .clk       (clk),
    .rst       (rst),
    .start     (state_q == ST_FETCH),
    .active    (state_q == ST_STREAM),
    .slot      (rd_ptr),
    .len       (cur_len),
    .byte_pop  (stream_vld && m_axis.m_tready),
    .last_byte (last_cnt),
    .byte_vld  (byte_vld),
    .byte_dat  (byte_dat),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (count != 2'd0) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_STREAM;
      ST_STREAM: if (hs && last_cnt) state_d = pad_act ? ST_PAD : ST_DONE;
      ST_PAD:    if (hs && last_cnt) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // The posted length stays untouched while its slot streams: wr_ptr only meets rd_ptr when count is 0 or 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q[0] <= '0;
      len_q[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      tx_drop  <= 1'b0;
    end else begin
      tx_drop <= tx_req && !accept;
      if (accept) begin
        len_q[wr_ptr] <= tx_len;
        wr_ptr        <= ~wr_ptr;
      end
      if (done) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, accept} - {1'b0, done};
    end
  end

  // One down-counter serves both the payload and, when enabled, the pad run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
    end else begin
      unique case (state_q)
        ST_FETCH:  rem_q <= cur_len;
        ST_STREAM: if (hs) rem_q <= (last_cnt && pad_act) ? (LEN_W'(MIN_LEN) - cur_len)
                                                          : (rem_q - LEN_W'(1));
        ST_PAD:    if (hs) rem_q <= rem_q - LEN_W'(1);
        default:   rem_q <= rem_q;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_sched.sv
// Scoreboard bench for eth_tx_sched: stimulus pushes expected bytes/addresses, a negedge monitor checks them.
module tb_eth_tx_sched;
  import eth_tx_pkg::*;

  typedef struct packed {
    logic       last;
    logic [7:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_req = 1'b0;
  len_t        tx_len = '0;
  logic        tx_ready, tx_wr_slot, tx_drop, tx_busy, tx_done;
  logic        mem_en;
  logic [10:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [15:0] mem [0:2*SLOT_WORDS-1];

  eth_tx_sched_if sif();

  eth_tx_sched dut (
    .clk        (clk),
    .rst        (rst),
    .tx_req     (tx_req),
    .tx_len     (tx_len),
    .tx_ready   (tx_ready),
    .tx_wr_slot (tx_wr_slot),
    .tx_drop    (tx_drop),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .m_axis     (sif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t byte_q[$];
  logic [10:0] addr_q[$];
  logic exp_wr   = 1'b0;
  int   exp_done = 0;
  int   done_cnt = 0;
  int   issued = 0, hs_cnt = 0, frame_bytes = 0;
  bit   in_frame = 0, prev_stall = 0, prev_last = 0, bp_mode = 0;
  logic [7:0] prev_data = '0;
  exp_t mon_e;

  function automatic logic [7:0] pat(input logic s, input int i);
    int v;
    v = s ? (8'h80 + 3 * i) : (i + 1);
    return v[7:0];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_frame(input logic s, input int len);
    int   total;
    exp_t e;
    total = len;
`ifdef ETH_TX_PAD_EN
    if (len < MIN_LEN_DEF) total = MIN_LEN_DEF;
`endif
    for (int w = 0; w < (len + 1) / 2; w++) addr_q.push_back({s, 10'(w)});
    for (int i = 0; i < total; i++) begin
      e.last = (i == total - 1);
      e.dat  = (i < len) ? pat(s, i) : 8'h00;
      byte_q.push_back(e);
    end
  endtask

  // Called right after a negedge; returns at the negedge following the sampling edge.
  task automatic post(input int len, input bit acc);
    check("wr_slot", tx_wr_slot, exp_wr);
    tx_req = 1'b1;
    tx_len = len_t'(len);
    if (acc) begin
      push_frame(exp_wr, len);
      exp_wr = ~exp_wr;
      exp_done++;
    end
    @(negedge clk);
    tx_req = 1'b0;
    tx_len = '0;
    check("drop", tx_drop, !acc);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (byte_q.size() == 0 && addr_q.size() == 0 && !tx_busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail({name, "_timeout"}, byte_q.size(), 0);
    check({name, "_done_cnt"}, done_cnt, exp_done);
  endtask

  task automatic chk_reset(input string name);
    check({name, "_tx_ready"}, tx_ready, 1);
    check({name, "_wr_slot"}, tx_wr_slot, 0);
    check({name, "_drop"}, tx_drop, 0);
    check({name, "_busy"}, tx_busy, 0);
    check({name, "_done"}, tx_done, 0);
    check({name, "_mem_en"}, mem_en, 0);
    check({name, "_mem_addr"}, mem_addr, 0);
    check({name, "_tvalid"}, sif.m_tvalid, 0);
    check({name, "_tlast"}, sif.m_tlast, 0);
    check({name, "_tdata"}, sif.m_tdata, 0);
  endtask

  initial begin
    sif.m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sif.m_tready = bp_mode ? ~sif.m_tready : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0; prev_stall = 0; issued = 0; hs_cnt = 0; frame_bytes = 0;
    end else begin
      if (tx_done) done_cnt++;
      if (prev_stall) begin
        check("hold_valid", sif.m_tvalid, 1);
        check("hold_data", sif.m_tdata, prev_data);
        check("hold_last", sif.m_tlast, prev_last);
      end
      if (in_frame && sif.m_tready) check("no_bubble", sif.m_tvalid, 1);
      if (mem_en) begin
        issued++;
        if (addr_q.size() == 0) fail("mem_addr_extra", mem_addr, 0);
        else check("mem_addr", mem_addr, addr_q.pop_front());
        check("outstanding_le2", (issued - hs_cnt / 2) <= 2, 1);
      end
      if (sif.m_tvalid && sif.m_tready) begin
        if (byte_q.size() == 0) begin
          fail("byte_extra", sif.m_tdata, 0);
        end else begin
          mon_e = byte_q.pop_front();
          check("tdata", sif.m_tdata, mon_e.dat);
          check("tlast", sif.m_tlast, mon_e.last);
        end
        hs_cnt++;
        frame_bytes++;
        in_frame = !sif.m_tlast;
        if (sif.m_tlast) begin
          issued = 0; hs_cnt = 0; frame_bytes = 0;
        end
      end
      prev_stall = sif.m_tvalid && !sif.m_tready;
      prev_data  = sif.m_tdata;
      prev_last  = sif.m_tlast;
    end
  end

  initial begin
    bit hit;
    for (int a = 0; a < 2 * SLOT_WORDS; a++)
      mem[a] = {pat(a >= SLOT_WORDS, 2 * (a % SLOT_WORDS) + 1), pat(a >= SLOT_WORDS, 2 * (a % SLOT_WORDS))};

    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    // len 8 in slot 0 with first-byte latency
    post(8, 1);
    check("lat_mem_en_T", mem_en, 0);
    @(negedge clk);
    check("lat_mem_en_T1", mem_en, 1);
    @(negedge clk);
    check("lat_tvalid_T2", sif.m_tvalid, 0);
    check("busy", tx_busy, 1);
    @(negedge clk);
    check("lat_tvalid_T3", sif.m_tvalid, 1);
    wait_idle("len8");

    // odd length in slot 1
    post(5, 1);
    wait_idle("len5");

    // backpressure on a 64-byte frame
    bp_mode = 1;
    post(64, 1);
    wait_idle("bp64");
    bp_mode = 0;
    @(negedge clk);

    // queue full and rejected posts
    post(6, 1);
    repeat (3) @(negedge clk);
    post(3, 1);
    check("ready_full", tx_ready, 0);
    post(7, 0);
    wait_idle("queue");
    post(0, 0);
    check("ready_len0", tx_ready, 1);
    wait_idle("len0");

    // short frame, padded only when compiled in
    post(10, 1);
    wait_idle("len10");

    // reset in the middle of a frame
    post(64, 1);
    hit = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (frame_bytes >= 20) begin
        hit = 1;
        break;
      end
    end
    check("reach_byte20", hit, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("midrst");
    byte_q.delete();
    addr_q.delete();
    exp_wr = 1'b0;
    exp_done--;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    post(4, 1);
    wait_idle("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end
endmodule
